// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the clk_div integer clock divider.
// The optional CLK_DIV_DUTY50_EN macro is consumed by clk_div only.
package clk_div_pkg;

    localparam int DIV_DEFAULT = 4;
    localparam int DIV_MIN     = 2;

    function automatic int cnt_width(input int div);
        int w;
        w = $clog2(div);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/clk_div_cnt.sv
// Modulo-DIV counter for clk_div; wrap flags the terminal count DIV-1.
module clk_div_cnt
    import clk_div_pkg::*;
#(
    parameter int DIV = DIV_DEFAULT,
    parameter int CW  = cnt_width(DIV)
) (
    input  logic          clk_in,
    input  logic          rst_b,
    output logic [CW-1:0] cnt,
    output logic          wrap
);

    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        wrap  = (cnt_q == LAST);
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk_in or negedge rst_b) begin
        if (!rst_b) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/clk_div.sv
// Integer clock divider: clk_out = clk_in / DIV plus a clk_en pulse per clk_out rise.
// Define CLK_DIV_DUTY50_EN for exact 50% duty on odd DIV (adds one falling-edge flop).
module clk_div
    import clk_div_pkg::*;
#(
    parameter int DIV = DIV_DEFAULT
) (
    input  logic clk_in,
    input  logic rst_b,
    output logic clk_out,
    output logic clk_en
);

    localparam int CW = cnt_width(DIV);
    localparam int HI = DIV / 2;

    generate
        if (DIV < DIV_MIN) begin : g_bad_div
            $error("clk_div: DIV=%0d is illegal, must be >= %0d", DIV, DIV_MIN);
        end
    endgenerate

    logic [CW-1:0] cnt;
    logic          wrap;

    clk_div_cnt #(
        .DIV (DIV),
        .CW  (CW)
    ) u_cnt (
        .clk_in (clk_in),
        .rst_b  (rst_b),
        .cnt    (cnt),
        .wrap   (wrap)
    );

    logic clk_pos_q, clk_pos_d;
    logic clk_en_q,  clk_en_d;

    always_comb begin
        clk_pos_d = (cnt < CW'(HI));
        clk_en_d  = (cnt == '0);
    end

    always_ff @(posedge clk_in or negedge rst_b) begin
        if (!rst_b) begin
            clk_pos_q <= 1'b0;
            clk_en_q  <= 1'b0;
        end else begin
            clk_pos_q <= clk_pos_d;
            clk_en_q  <= clk_en_d;
        end
    end

    assign clk_en = clk_en_q;

`ifdef CLK_DIV_DUTY50_EN
    generate
        if ((DIV % 2) == 1) begin : g_duty50
            // Half-cycle delayed copy stretches the high phase by T/2 to reach DIV/2.0 cycles.
            logic clk_neg_q;
            always_ff @(negedge clk_in or negedge rst_b) begin
                if (!rst_b) begin
                    clk_neg_q <= 1'b0;
                end else begin
                    clk_neg_q <= clk_pos_q;
                end
            end
            assign clk_out = clk_pos_q | clk_neg_q;
        end else begin : g_even
            assign clk_out = clk_pos_q;
        end
    endgenerate
`else
    assign clk_out = clk_pos_q;
`endif

`ifndef SYNTHESIS
    a_cnt_range: assert property (@(posedge clk_in) disable iff (!rst_b) int'(cnt) < DIV);
    a_wrap_zero: assert property (@(posedge clk_in) disable iff (!rst_b) wrap |=> (cnt == '0));
    a_en_width:  assert property (@(posedge clk_in) disable iff (!rst_b) clk_en |=> !clk_en);
    a_en_high:   assert property (@(posedge clk_in) disable iff (!rst_b) clk_en |-> clk_pos_q);
`endif

endmodule

// File: tb/tb_clk_div.sv
// Directed self-checking bench for clk_div at DIV=4, DIV=2 and DIV=5.
// Odd-DIV expectations follow CLK_DIV_DUTY50_EN when the bench is built with it.
module tb_clk_div;

    logic clk_in = 1'b0;
    logic rst_b  = 1'b0;
    logic out4, en4, out2, en2, out5, en5;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_in = ~clk_in;

    clk_div #(.DIV(4)) dut4 (.clk_in(clk_in), .rst_b(rst_b), .clk_out(out4), .clk_en(en4));
    clk_div #(.DIV(2)) dut2 (.clk_in(clk_in), .rst_b(rst_b), .clk_out(out2), .clk_en(en2));
    clk_div #(.DIV(5)) dut5 (.clk_in(clk_in), .rst_b(rst_b), .clk_out(out5), .clk_en(en5));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    initial begin
        int pulses4;
        pulses4 = 0;

        repeat (2) @(posedge clk_in);
        #1;
        check("rst_out4", out4, 0);
        check("rst_en4",  en4,  0);
        check("rst_out2", out2, 0);
        check("rst_en2",  en2,  0);
        check("rst_out5", out5, 0);
        check("rst_en5",  en5,  0);
        check("rst_cnt4", dut4.cnt, 0);

        @(negedge clk_in);
        rst_b = 1'b1;

        for (int k = 0; k < 100; k++) begin
            @(posedge clk_in);
            #1;
            check("out4", out4, ((k % 4) < 2) ? 1 : 0);
            check("en4",  en4,  ((k % 4) == 0) ? 1 : 0);
            check("out2", out2, ((k % 2) == 0) ? 1 : 0);
            check("en2",  en2,  ((k % 2) == 0) ? 1 : 0);
            check("en5",  en5,  ((k % 5) == 0) ? 1 : 0);
`ifdef CLK_DIV_DUTY50_EN
            // clk_neg still holds the previous high, so just after a rise edge the window is 3 cycles
            check("out5_pos", out5, ((k % 5) < 3) ? 1 : 0);
`else
            check("out5_pos", out5, ((k % 5) < 2) ? 1 : 0);
`endif
            if (en4) pulses4++;
            @(negedge clk_in);
            #1;
            check("out5_neg", out5, ((k % 5) < 2) ? 1 : 0);
        end
        check("pulses4", pulses4, 25);

        // Edge index 100: DIV=4 in its high phase with cnt=1, clk_en high.
        @(posedge clk_in);
        #1;
        check("pre_out4", out4, 1);
        check("pre_en4",  en4,  1);
        check("pre_cnt4", dut4.cnt, 1);
        #2;
        rst_b = 1'b0;
        #1;
        check("async_out4", out4, 0);
        check("async_en4",  en4,  0);
        check("async_cnt4", dut4.cnt, 0);
        check("async_out5", out5, 0);

        @(posedge clk_in);
        #1;
        check("hold_out4", out4, 0);
        @(negedge clk_in);
        rst_b = 1'b1;
        @(posedge clk_in);
        #1;
        check("rel_out4", out4, 1);
        check("rel_en4",  en4,  1);
        check("rel_out2", out2, 1);
        check("rel_en5",  en5,  1);
        check("rel_cnt4", dut4.cnt, 1);
        @(posedge clk_in);
        #1;
        check("rel1_out4", out4, 1);
        check("rel1_en4",  en4,  0);
        check("rel1_out2", out2, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
